// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared state encoding and register-address width for pipeline stages
package pipe_stage_reg_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// rtl/pipe_stage_reg_entry.sv - one held pipeline entry {valid, data, rd_addr, rd_valid}
module pipe_entry_reg #(
   parameter int DATA_W         = 128,
   parameter int RD_W           = 5,
   parameter int CLEAR_ON_FLUSH = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [RD_W-1:0]   d_rd_addr,
   input  logic              d_rd_valid,
   output logic              q_valid,
   output logic [DATA_W-1:0] q_data,
   output logic [RD_W-1:0]   q_rd_addr,
   output logic              q_rd_valid
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q_valid    <= 1'b0;
         q_data     <= '0;
         q_rd_addr  <= '0;
         q_rd_valid <= 1'b0;
      end else if (flush) begin
         q_valid    <= 1'b0;
         q_rd_valid <= 1'b0;
         if (CLEAR_ON_FLUSH != 0) begin
            q_data    <= '0;
            q_rd_addr <= '0;
         end
      end else if (load) begin
         q_valid    <= 1'b1;
         q_data     <= d_data;
         q_rd_addr  <= d_rd_addr;
         q_rd_valid <= d_rd_valid;
      end else if (clear) begin
         // a consumed entry must never look like a writer to forwarding logic
         q_valid    <= 1'b0;
         q_rd_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with flush and optional skid entry
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int DATA_W         = 128,
   parameter int RD_W           = REG_ADDR_W,
   parameter int SKID_EN        = 1,
   parameter int CLEAR_ON_FLUSH = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [RD_W-1:0]   in_rd_addr,
   input  logic              in_rd_valid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [RD_W-1:0]   out_rd_addr,
   output logic              out_rd_valid,
   output logic [1:0]        occupancy
);

   stage_state_t      state, state_nx;
   logic              in_xfer, out_xfer;
   logic              head_load, head_clear, skid_load, skid_clear;
   logic              head_valid, head_rd_valid;
   logic [DATA_W-1:0] head_d_data;
   logic [RD_W-1:0]   head_d_rd_addr;
   logic              head_d_rd_valid;
   logic              skid_valid, skid_rd_valid;
   logic [DATA_W-1:0] skid_data;
   logic [RD_W-1:0]   skid_rd_addr;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush) state <= ST_EMPTY;
      else              state <= state_nx;
   end

   // without a skid entry in_ready in ONE needs out_ready, so ONE never goes to TWO
   always_comb begin
      state_nx = state;
      case (state)
         ST_EMPTY: if (in_xfer) state_nx = ST_ONE;
         ST_ONE: begin
            if (in_xfer && !out_xfer)      state_nx = ST_TWO;
            else if (!in_xfer && out_xfer) state_nx = ST_EMPTY;
         end
         ST_TWO:   if (out_xfer) state_nx = ST_ONE;
         default:  state_nx = ST_EMPTY;
      endcase
   end

   always_comb begin
      head_load       = 1'b0;
      head_clear      = 1'b0;
      skid_load       = 1'b0;
      skid_clear      = 1'b0;
      head_d_data     = in_data;
      head_d_rd_addr  = in_rd_addr;
      head_d_rd_valid = in_rd_valid;
      if (SKID_EN != 0) in_ready = !rst && (state != ST_TWO);
      else              in_ready = !rst && ((state == ST_EMPTY) || out_ready);
      case (state)
         ST_EMPTY: head_load = in_xfer;
         ST_ONE: begin
            head_load  = in_xfer && out_xfer;
            head_clear = out_xfer && !in_xfer;
            skid_load  = in_xfer && !out_xfer;
         end
         ST_TWO: begin
            head_load       = out_xfer;
            skid_clear      = out_xfer;
            head_d_data     = skid_data;
            head_d_rd_addr  = skid_rd_addr;
            head_d_rd_valid = skid_rd_valid;
         end
         default: ;
      endcase
   end

   pipe_entry_reg #(
      .DATA_W(DATA_W), .RD_W(RD_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
   ) u_head (
      .clk(clk), .rst(rst), .flush(flush), .load(head_load), .clear(head_clear),
      .d_data(head_d_data), .d_rd_addr(head_d_rd_addr), .d_rd_valid(head_d_rd_valid),
      .q_valid(head_valid), .q_data(out_data), .q_rd_addr(out_rd_addr),
      .q_rd_valid(head_rd_valid)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         pipe_entry_reg #(
            .DATA_W(DATA_W), .RD_W(RD_W), .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
         ) u_skid (
            .clk(clk), .rst(rst), .flush(flush), .load(skid_load), .clear(skid_clear),
            .d_data(in_data), .d_rd_addr(in_rd_addr), .d_rd_valid(in_rd_valid),
            .q_valid(skid_valid), .q_data(skid_data), .q_rd_addr(skid_rd_addr),
            .q_rd_valid(skid_rd_valid)
         );
      end else begin : g_no_skid
         logic unused_skid_ctl;
         assign unused_skid_ctl = skid_load | skid_clear;
         assign skid_valid      = 1'b0;
         assign skid_data       = '0;
         assign skid_rd_addr    = '0;
         assign skid_rd_valid   = 1'b0;
      end
   endgenerate

   assign out_valid    = head_valid;
   assign out_rd_valid = head_rd_valid && head_valid;
   assign occupancy    = {1'b0, head_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed bench for skid and non-skid pipe_stage_reg variants
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_rd_valid, out_ready;
   logic [15:0] in_data;
   logic [4:0]  in_rd_addr;

   logic        s_in_ready, s_out_valid, s_out_rd_valid;
   logic [15:0] s_out_data;
   logic [4:0]  s_out_rd_addr;
   logic [1:0]  s_occ;

   logic        n_in_ready, n_out_valid, n_out_rd_valid;
   logic [15:0] n_out_data;
   logic [4:0]  n_out_rd_addr;
   logic [1:0]  n_occ;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(16), .RD_W(5), .SKID_EN(1), .CLEAR_ON_FLUSH(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
      .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_rd_addr(s_out_rd_addr), .out_rd_valid(s_out_rd_valid), .occupancy(s_occ)
   );

   pipe_stage_reg #(.DATA_W(16), .RD_W(5), .SKID_EN(0), .CLEAR_ON_FLUSH(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data),
      .in_rd_addr(in_rd_addr), .in_rd_valid(in_rd_valid),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
      .out_rd_addr(n_out_rd_addr), .out_rd_valid(n_out_rd_valid), .occupancy(n_occ)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd_valid = 1'b0;
      out_ready = 1'b0; in_data = '0; in_rd_addr = '0;
      tick(); tick();
      chk("rst_in_ready", 32'(s_in_ready), 0);
      chk("rst_out_valid", 32'(s_out_valid), 0);
      chk("rst_occ", 32'(s_occ), 0);
      chk("rst_out_data", 32'(s_out_data), 0);

      // reset and fill
      in_valid = 1'b1; in_data = 16'h00A5; in_rd_addr = 5'd7; in_rd_valid = 1'b1;
      out_ready = 1'b1; rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(s_in_ready), 1);
      chk("post_rst_out_valid", 32'(s_out_valid), 0);
      tick();
      in_valid = 1'b0;
      chk("fill_out_valid", 32'(s_out_valid), 1);
      chk("fill_out_data", 32'(s_out_data), 32'h00A5);
      chk("fill_rd_addr", 32'(s_out_rd_addr), 7);
      chk("fill_rd_valid", 32'(s_out_rd_valid), 1);
      chk("fill_occ", 32'(s_occ), 1);
      tick();
      chk("drain_occ", 32'(s_occ), 0);

      // backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd1;
      tick();
      in_data = 16'd2;
      tick();
      chk("bp_occ2", 32'(s_occ), 2);
      chk("bp_in_ready", 32'(s_in_ready), 0);
      in_data = 16'd3;
      tick();
      chk("bp_hold_occ", 32'(s_occ), 2);
      chk("bp_hold_data", 32'(s_out_data), 1);
      out_ready = 1'b1;
      tick();
      chk("bp_out2", 32'(s_out_data), 2);
      chk("bp_out2_occ", 32'(s_occ), 1);
      tick();
      in_valid = 1'b0;
      chk("bp_out3", 32'(s_out_data), 3);
      chk("bp_out3_valid", 32'(s_out_valid), 1);
      tick();
      chk("bp_empty", 32'(s_out_valid), 0);

      // flush with both entries full and D4 offered
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
      tick();
      in_data = 16'h0022;
      tick();
      in_data = 16'h0044; flush = 1'b1;
      #1;
      chk("fl_in_ready_same", 32'(s_in_ready), 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", 32'(s_out_valid), 0);
      chk("fl_rd_valid", 32'(s_out_rd_valid), 0);
      chk("fl_occ", 32'(s_occ), 0);
      chk("fl_in_ready", 32'(s_in_ready), 1);
      chk("fl_zero_data", 32'(s_out_data), 0);
      chk("fl_zero_addr", 32'(s_out_rd_addr), 0);
      tick();
      chk("fl_no_d4", 32'(s_out_valid), 0);

      // streaming
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 16'(i);
         tick();
         chk("st_data", 32'(s_out_data), 32'(i));
         chk("st_occ", 32'(s_occ), 1);
         chk("st_in_ready", 32'(s_in_ready), 1);
      end
      in_valid = 1'b0;
      tick();

      // non-skid variant
      rst = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
      tick();
      chk("ns_occ_full", 32'(n_occ), 1);
      chk("ns_in_ready_full", 32'(n_in_ready), 0);
      out_ready = 1'b1;
      #1;
      chk("ns_in_ready_comb", 32'(n_in_ready), 1);
      in_data = 16'h0066;
      tick();
      chk("ns_swap_occ", 32'(n_occ), 1);
      chk("ns_swap_data", 32'(n_out_data), 32'h0066);
      in_data = 16'h0077; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("ns_fl_valid", 32'(n_out_valid), 0);
      chk("ns_fl_keep_data", 32'(n_out_data), 32'h0066);
      chk("ns_fl_occ", 32'(n_occ), 0);

      // reset mid-stream with flush
      out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0081;
      tick();
      in_data = 16'h0082;
      tick();
      chk("mr_occ2", 32'(s_occ), 2);
      rst = 1'b1; flush = 1'b1;
      #1;
      chk("mr_in_ready_rst", 32'(s_in_ready), 0);
      tick();
      chk("mr_out_valid", 32'(s_out_valid), 0);
      chk("mr_out_data", 32'(s_out_data), 0);
      chk("mr_rd_addr", 32'(s_out_rd_addr), 0);
      chk("mr_rd_valid", 32'(s_out_rd_valid), 0);
      chk("mr_occ", 32'(s_occ), 0);
      chk("mr_in_ready_hold", 32'(s_in_ready), 0);
      chk("mr_ns_data", 32'(n_out_data), 0);
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_rd_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("mr_in_ready_after", 32'(s_in_ready), 1);

      // bubbles never look like writers
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bub_s_rd_valid", 32'(s_out_rd_valid), 0);
         chk("bub_n_rd_valid", 32'(n_out_rd_valid), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
